// File: rtl/ramr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ramr_pkg
// Description : Shared definitions for the fifoe reader: state codes, default
//               inter-byte timeout and frame-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ramr_pkg;

    typedef enum logic [7:0] {
        RD_IDLE = 8'h00,
        RD_WAIT = 8'h01,
        RD_READ = 8'h02,
        RD_DONE = 8'h03
    } ramr_state_t;

    localparam logic [15:0] RAMR_TOUT_DEFAULT = 16'd1000;

    // Bytes pulled from the FIFO per frame: the command plus an optional trailer.
    function automatic int ramr_frame_len(input int num, input bit chk_en);
        return chk_en ? num + 1 : num;
    endfunction

endpackage : ramr_pkg
`default_nettype wire

// File: rtl/ramr_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ramr_cnt
// Description : Captured-byte counter and inter-byte idle counter with a
//               shared clear and terminal flags for the fifoe reader.
// Revision    : 1.0 - initial release
// ============================================================================
module ramr_cnt #(
    parameter int          BYTE_W   = 4,
    parameter int          BYTE_MAX = 12,
    parameter logic [15:0] TOUT     = 16'd1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_inc,
    input  logic              idle_inc,
    output logic [BYTE_W-1:0] byte_cnt,
    output logic              byte_term,
    output logic              idle_term
);

    localparam logic [BYTE_W-1:0] c_BYTE_MAX  = BYTE_W'(BYTE_MAX);
    localparam logic [15:0]       c_IDLE_LAST = TOUT - 16'd1;

    logic [BYTE_W-1:0] r_byte_cnt;
    logic [15:0]       r_idle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= '0;
            r_idle_cnt <= '0;
        end else if (clr) begin
            r_byte_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            if (byte_inc) begin
                r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
                r_idle_cnt <= '0;
            end else if (idle_inc && (r_idle_cnt != 16'hFFFF)) begin
                r_idle_cnt <= r_idle_cnt + 16'd1;
            end
        end
    end

    assign byte_cnt  = r_byte_cnt;
    assign byte_term = (r_byte_cnt == c_BYTE_MAX);
    // Flags the idle cycle that completes TOUT cycles since the last byte.
    assign idle_term = (r_idle_cnt >= c_IDLE_LAST);

endmodule : ramr_cnt
`default_nettype wire

// File: rtl/ramr.sv
`default_nettype none
// ============================================================================
// Module      : ramr
// Description : Reads one NUM-byte command frame from the fifoe byte FIFO and
//               presents it on cmd_tx. Optional XOR trailer check is enabled
//               with the RAMR_CHK_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module ramr
    import ramr_pkg::*;
#(
    parameter int          NUM  = 12,
    parameter logic [15:0] TOUT = RAMR_TOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fs,
    output logic             fd,
    input  logic [7:0]       fifoe_rxd,
    input  logic             fifoe_empty,
    output logic             fifoe_rxen,
    output logic [8*NUM-1:0] cmd_tx,
    output logic             cmd_err,
    output logic [7:0]       so
);

`ifdef RAMR_CHK_EN
    localparam bit c_CHK = 1'b1;
`else
    localparam bit c_CHK = 1'b0;
`endif

    localparam int                c_FRM_I = ramr_frame_len(NUM, c_CHK);
    localparam int                c_CNT_W = $clog2(c_FRM_I + 1);
    localparam logic [c_CNT_W-1:0] c_FRM  = c_CNT_W'(c_FRM_I);
    localparam logic [c_CNT_W-1:0] c_NUM  = c_CNT_W'(NUM);

    ramr_state_t        r_state;
    ramr_state_t        w_state_nxt;
    logic [c_CNT_W-1:0] r_issued;
    logic               r_rd_vld;
    logic [8*NUM-1:0]   r_sh;

    logic [c_CNT_W-1:0] w_byte_cnt;
    logic               w_byte_term;
    logic               w_idle_term;
    logic               w_clr;
    logic               w_byte_inc;
    logic               w_idle_inc;
    logic               w_timeout;
    logic               w_rxen;
    logic               w_frame_exit;
    logic               w_timeout_exit;
    logic               w_chk_err;

    assign w_clr      = (r_state == RD_IDLE);
    assign w_byte_inc = r_rd_vld && (r_state == RD_READ);
    assign w_idle_inc = ((r_state == RD_WAIT) || (r_state == RD_READ)) && !w_byte_inc;
    assign w_timeout  = w_idle_inc && w_idle_term;

    ramr_cnt #(
        .BYTE_W   (c_CNT_W),
        .BYTE_MAX (c_FRM_I),
        .TOUT     (TOUT)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_clr),
        .byte_inc  (w_byte_inc),
        .idle_inc  (w_idle_inc),
        .byte_cnt  (w_byte_cnt),
        .byte_term (w_byte_term),
        .idle_term (w_idle_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rxen         = 1'b0;
        w_frame_exit   = 1'b0;
        w_timeout_exit = 1'b0;
        case (r_state)
            RD_IDLE: begin
                if (fs) begin
                    w_state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (!fifoe_empty) begin
                    w_state_nxt = RD_READ;
                end else if (w_timeout) begin
                    w_state_nxt    = RD_DONE;
                    w_timeout_exit = 1'b1;
                end
            end
            RD_READ: begin
                if (w_byte_term) begin
                    w_state_nxt  = RD_DONE;
                    w_frame_exit = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt    = RD_DONE;
                    w_timeout_exit = 1'b1;
                end else if (!fifoe_empty && (r_issued < c_FRM)) begin
                    // Gated by the live empty flag so no read is issued the cycle it rises.
                    w_rxen = 1'b1;
                end
            end
            RD_DONE: begin
                if (!fs) begin
                    w_state_nxt = RD_IDLE;
                end
            end
            default: begin
                w_state_nxt = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issued <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_rxen;
            if (w_clr) begin
                r_issued <= '0;
            end else if (w_rxen) begin
                r_issued <= r_issued + c_CNT_W'(1);
            end
        end
    end

    // Only command bytes enter the shift register; a trailer is checked separately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh <= '0;
        end else if (w_clr) begin
            r_sh <= '0;
        end else if (w_byte_inc && (w_byte_cnt < c_NUM)) begin
            r_sh <= {r_sh[8*NUM-9:0], fifoe_rxd};
        end
    end

`ifdef RAMR_CHK_EN
    logic [7:0] r_xor;
    logic       r_chk_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xor     <= '0;
            r_chk_bad <= 1'b0;
        end else if (w_clr) begin
            r_xor     <= '0;
            r_chk_bad <= 1'b0;
        end else if (w_byte_inc) begin
            if (w_byte_cnt < c_NUM) begin
                r_xor <= r_xor ^ fifoe_rxd;
            end else begin
                r_chk_bad <= (fifoe_rxd != r_xor);
            end
        end
    end

    assign w_chk_err = r_chk_bad;
`else
    assign w_chk_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_tx  <= '0;
            cmd_err <= 1'b0;
        end else begin
            if ((r_state == RD_IDLE) && fs) begin
                cmd_err <= 1'b0;
            end
            if (w_frame_exit) begin
                cmd_err <= w_chk_err;
                if (!w_chk_err) begin
                    cmd_tx <= r_sh;
                end
            end else if (w_timeout_exit) begin
                cmd_err <= 1'b1;
            end
        end
    end

    assign fifoe_rxen = w_rxen;
    assign fd         = (r_state == RD_DONE);
    assign so         = r_state;

endmodule : ramr
`default_nettype wire
